// File: rtl/serial_digit_adder.sv
// Digit-serial adder: S = X + Y + Cin, DIGIT bits per clock, LSB digit first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_DIGIT_ADDER_OVF_EN.
module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   xr_q, xr_d, yr_q, yr_d, sr_q, sr_d, s_q, s_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT:0]     dsum;
    logic [WIDTH-1:0]   d_ext, sum_nxt;
    logic               last;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    logic               xm_q, xm_d, ym_q, ym_d, ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            sr_q    <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            sr_q    <= sr_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        sr_d    = sr_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
        xm_d    = xm_q;
        ym_d    = ym_q;
        ovf_d   = ovf_q;
`endif
        // One digit of the ripple, carry kept in the extra top bit.
        dsum    = {1'b0, xr_q[DIGIT-1:0]} + {1'b0, yr_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        d_ext   = '0;
        d_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
        sum_nxt = (sr_q >> DIGIT) | (d_ext << (WIDTH - DIGIT));
        last    = (cnt_q == CNT_W'(N - 1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
                    xm_d    = x[WIDTH-1];
                    ym_d    = y[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                xr_d    = xr_q >> DIGIT;
                yr_d    = yr_q >> DIGIT;
                sr_d    = sum_nxt;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    // Result registers change only here, so s/cout hold through IDLE and RUN.
                    s_d     = sum_nxt;
                    cout_d  = dsum[DIGIT];
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
                    ovf_d   = (xm_q == ym_q) && (sum_nxt[WIDTH-1] != xm_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: WIDTH=8 with DIGIT=2 (u_dut) and DIGIT=8 (u_dut8), scoreboard of expected sums.
module tb_serial_digit_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, cin = 1'b0, cout, busy;
    logic [7:0] x = '0, y = '0, s;
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, cin8 = 1'b0, cout8, busy8;
    logic [7:0] x8 = '0, y8 = '0, s8;
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    logic       ovf, ovf8;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t e;
    int   lat;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8),
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
        .ovf(ovf8),
`endif
        .busy(busy8)
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        exp_t r;
        t   = {1'b0, a} + {1'b0, b} + {8'd0, c};
        r.s = t[7:0];
        r.c = t[8];
        r.o = (a[7] == b[7]) && (t[7] != a[7]);
        return r;
    endfunction

    // Offer one operand set for a single edge, then scramble the inputs.
    task automatic send(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic c);
        if (w8) begin
            x8 = a; y8 = b; cin8 = c; in_valid8 = 1'b1;
        end else begin
            x = a; y = b; cin = c; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid8 = 1'b0;
        x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
        x8 = 8'($urandom); y8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic wait_out(input bit w8, output int cycles);
        cycles = 0;
        while (!(w8 ? out_valid8 : out_valid) && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!(w8 ? out_valid8 : out_valid)) cycles = -1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ov=%b ir=%b busy=%b s=%h cout=%b, want 0 1 0 00 0",
                     out_valid, in_ready, busy, s, cout);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        sb.push_back(model(8'h12, 8'h34, 1'b1));
        send(1'b0, 8'h12, 8'h34, 1'b1);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run_flags: got busy=%b ir=%b, want 1 0", busy, in_ready);
        end
        wait_out(1'b0, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d, want 4", lat); end
        e = sb.pop_front();
        vectors++;
        if (s !== e.s || cout !== e.c || s !== 8'h47) begin
            miscompares++;
            $display("FAIL basic_sum: got s=%h cout=%b, want s=%h cout=%b", s, cout, e.s, e.c);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 8'h47) begin
            miscompares++;
            $display("FAIL basic_one_cycle: got ov=%b ir=%b s=%h, want 0 1 47", out_valid, in_ready, s);
        end
    endtask

    task automatic test_ripple;
        sb.push_back(model(8'hFF, 8'h01, 1'b0));
        send(1'b0, 8'hFF, 8'h01, 1'b0);
        wait_out(1'b0, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL ripple_latency: got %0d, want 4", lat); end
        e = sb.pop_front();
        vectors++;
        if (s !== e.s || cout !== e.c || s !== 8'h00 || cout !== 1'b1) begin
            miscompares++;
            $display("FAIL ripple_sum: got s=%h cout=%b, want s=%h cout=%b", s, cout, e.s, e.c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        sb.push_back(model(8'hA5, 8'h5A, 1'b1));
        send(1'b0, 8'hA5, 8'h5A, 1'b1);
        wait_out(1'b0, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL bp_latency: got %0d, want 4", lat); end
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== e.s || cout !== e.c) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b s=%h cout=%b, want 1 0 %h %b",
                         i, out_valid, in_ready, s, cout, e.s, e.c);
            end
            in_valid = (i == 2);
            x = 8'h11; y = 8'h22; cin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || s !== e.s || cout !== e.c) begin
            miscompares++;
            $display("FAIL bp_release: got ov=%b ir=%b busy=%b s=%h cout=%b, want 0 1 0 %h %b",
                     out_valid, in_ready, busy, s, cout, e.s, e.c);
        end
        sb.push_back(model(8'h11, 8'h22, 1'b0));
        send(1'b0, 8'h11, 8'h22, 1'b0);
        wait_out(1'b0, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL bp_second_latency: got %0d, want 4", lat); end
        e = sb.pop_front();
        vectors++;
        if (s !== e.s || cout !== e.c) begin
            miscompares++;
            $display("FAIL bp_second_sum: got s=%h cout=%b, want s=%h cout=%b", s, cout, e.s, e.c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset;
        send(1'b0, 8'h55, 8'h66, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy: got %b, want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got ov=%b ir=%b busy=%b s=%h cout=%b, want 0 1 0 00 0",
                     out_valid, in_ready, busy, s, cout);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(8'h03, 8'h04, 1'b0));
        send(1'b0, 8'h03, 8'h04, 1'b0);
        wait_out(1'b0, lat);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL abort_new_latency: got %0d, want 4", lat); end
        e = sb.pop_front();
        vectors++;
        if (s !== e.s || cout !== e.c || s !== 8'h07) begin
            miscompares++;
            $display("FAIL abort_new_sum: got s=%h cout=%b, want s=%h cout=%b", s, cout, e.s, e.c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_digit;
        sb.push_back(model(8'hC8, 8'h64, 1'b1));
        send(1'b1, 8'hC8, 8'h64, 1'b1);
        wait_out(1'b1, lat);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL n1_latency: got %0d, want 1", lat); end
        e = sb.pop_front();
        vectors++;
        if (s8 !== e.s || cout8 !== e.c || s8 !== 8'h2D) begin
            miscompares++;
            $display("FAIL n1_sum: got s=%h cout=%b, want s=%h cout=%b", s8, cout8, e.s, e.c);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL n1_release: got ov=%b ir=%b, want 0 1", out_valid8, in_ready8);
        end
    endtask

`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    task automatic test_ovf;
        logic [7:0] av[3];
        logic [7:0] bv[3];
        av = '{8'h7F, 8'h80, 8'h10};
        bv = '{8'h01, 8'h80, 8'hF0};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(av[i], bv[i], 1'b0));
            send(1'b0, av[i], bv[i], 1'b0);
            wait_out(1'b0, lat);
            e = sb.pop_front();
            vectors++;
            if (lat !== 4 || s !== e.s || cout !== e.c || ovf !== e.o) begin
                miscompares++;
                $display("FAIL ovf[%0d]: got lat=%0d s=%h cout=%b ovf=%b, want 4 %h %b %b",
                         i, lat, s, cout, ovf, e.s, e.c, e.o);
            end
            @(posedge clk); #1;
            vectors++;
            if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear[%0d]: got %b, want 0", i, ovf); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_midrun_reset();
        test_single_digit();
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
